// File: rtl/uart_packet_pkg.sv
// Frame constants, FSM encoding and byte selection shared by the packet transmitter.
// Define UART_PKT_CHECKSUM_EN to add an XOR checksum byte before the tail (7-byte frame).
package uart_packet_pkg;

    localparam logic [7:0] HEAD = 8'hFF;
    localparam logic [7:0] TAIL = 8'hFF;
`ifdef UART_PKT_CHECKSUM_EN
    localparam int FRAME_LEN = 7;
`else
    localparam int FRAME_LEN = 6;
`endif
    localparam int BYTE_CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } state_t;

    typedef struct packed {
        logic [4:0] location;
        logic [3:0] shape;
        logic [3:0] color;
        logic [3:0] angle;
    } fields_t;

    function automatic logic [7:0] frame_byte(input logic [BYTE_CNT_W-1:0] idx, input fields_t f);
        logic [7:0] b;
        case (idx)
            3'd0:    b = HEAD;
            3'd1:    b = {3'b000, f.location};
            3'd2:    b = {4'b0000, f.shape};
            3'd3:    b = {4'b0000, f.color};
            3'd4:    b = {4'b0000, f.angle};
`ifdef UART_PKT_CHECKSUM_EN
            3'd5:    b = {3'b000, f.location ^ {1'b0, f.shape} ^ {1'b0, f.color} ^ {1'b0, f.angle}};
`endif
            default: b = TAIL;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_packet_tx_byte.sv
// 8N1 byte serializer: start bit on the edge after tx_start, each bit BAUD_DIV cycles.
// No backpressure: tx_start is honoured only while idle; BAUD_DIV must be at least 2.
module uart_byte_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_byte_done
);
    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] BAUD_WARN = CNT_W'(BAUD_DIV - 2);

    logic [CNT_W-1:0] baud_cnt;
    logic [3:0]       bit_idx;
    logic [7:0]       shreg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (!tx_busy) begin
            if (tx_start) begin
                shreg    <= tx_data;
                tx       <= 1'b0;
                tx_busy  <= 1'b1;
                baud_cnt <= '0;
                bit_idx  <= '0;
            end
        end else if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 4'd9) begin
                tx_busy <= 1'b0;
                tx      <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                tx      <= (bit_idx < 4'd8) ? shreg[bit_idx[2:0]] : 1'b1;
            end
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    // Fires two cycles before the stop bit ends, so the next start bit can follow one idle cycle.
    assign tx_byte_done = tx_busy && (bit_idx == 4'd9) && (baud_cnt == BAUD_WARN);

endmodule

// File: rtl/uart_packet_tx.sv
// Captures one object record and sends it as a HEAD/fields/TAIL UART frame; first start bit 2 cycles after accept.
// pkt_ready is high only while idle; requests arriving during a frame are dropped, not queued.
module uart_packet_tx
    import uart_packet_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       pkt_valid,
    output logic       pkt_ready,
    input  logic [4:0] location,
    input  logic [3:0] shape,
    input  logic [3:0] color,
    input  logic [3:0] angle,
    output logic       uart_tx,
    output logic       tx_done
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(FRAME_LEN - 1);

    state_t                  state;
    fields_t                 fld;
    logic [BYTE_CNT_W-1:0]   byte_cnt;
    logic                    tx_start;
    logic [7:0]              tx_data;
    logic                    tx_busy;
    logic                    byte_done;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            fld       <= '0;
            byte_cnt  <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            pkt_ready <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            tx_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pkt_valid && pkt_ready) begin
                        fld       <= {location, shape, color, angle};
                        byte_cnt  <= '0;
                        pkt_ready <= 1'b0;
                        state     <= LOAD;
                    end else begin
                        pkt_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    tx_data  <= frame_byte(byte_cnt, fld);
                    tx_start <= 1'b1;
                    state    <= SEND;
                end
                SEND: begin
                    if (byte_done) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state <= DONE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= LOAD;
                        end
                    end
                end
                DONE: begin
                    // Serializer still busy means the final stop bit is just completing.
                    if (tx_busy) begin
                        tx_done <= 1'b1;
                    end else begin
                        pkt_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

    uart_byte_tx #(
        .BAUD_DIV(BAUD_DIV)
    ) u_byte_tx (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx          (uart_tx),
        .tx_busy     (tx_busy),
        .tx_byte_done(byte_done)
    );

endmodule
